// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter paced by an external baud generator.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx_fifo #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic       rs232_tx,
  output logic       busy
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   C_FULL    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   C_CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] C_PTR_ONE = FIFO_AW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_tx_ready;
  logic [2:0]         r_state;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_cnt;
  logic               r_bps_start;
  logic               r_tx;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [FIFO_AW:0]   w_count_next;

  assign w_empty = (r_count == '0);
  assign w_push  = tx_valid && r_tx_ready;
  // DONE pops directly so back-to-back frames keep bps_start low for a single cycle.
  assign w_pop   = ((r_state == S_IDLE) || (r_state == S_DONE)) && !w_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count    <= w_count_next;
      r_tx_ready <= (w_count_next != C_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_bps_start <= 1'b0;
      r_tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_bps_start <= w_pop;
          r_state     <= w_pop ? S_WAIT : S_IDLE;
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
            r_parity <= ^r_mem[r_rd_ptr];
`endif
          end
        end
        S_WAIT: begin
          if (clk_bps) begin
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (clk_bps) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (clk_bps) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (clk_bps) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (clk_bps) begin
            r_bps_start <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_bps_start <= 1'b0;
          r_tx        <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready  = r_tx_ready;
  assign bps_start = r_bps_start;
  assign rs232_tx  = r_tx;
  assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule
